// File: rtl/mac_cfg_loader.sv
// Config loader for one MAC cluster: assembles narrow beats into a cfg word,
// pulses cset on commit and holds the cluster en low until the config settles.
module mac_cfg_loader #(
   parameter int MAC_CONF_WIDTH = 4,
   parameter int MAC_ACC_WIDTH  = 32,
   parameter int IN_WIDTH       = 16,
   parameter int SETTLE_CYCLES  = 2,
   localparam int CFG_WIDTH = 4*MAC_ACC_WIDTH+MAC_CONF_WIDTH,
   localparam int BEATS = (CFG_WIDTH+IN_WIDTH-1)/IN_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_data,
   input  logic                 cfg_abort,
   input  logic                 run_en,
   output logic [CFG_WIDTH-1:0] cfg,
   output logic                 cset,
   output logic                 mac_en,
   output logic                 cfg_loaded
);

   localparam int ASM_W = BEATS*IN_WIDTH;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      COMMIT,
      SETTLE,
      RUN
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [SET_W-1:0] set_q;
   logic [ASM_W-1:0] asm_q;
   logic [ASM_W-1:0] asm_nxt;
   logic [CNT_W-1:0] idx;
   logic             last;
   logic             accept;

   // A beat taken outside LOAD always starts a fresh image at slot 0
   always_comb begin
      idx     = (state_q == LOAD) ? cnt_q : '0;
      asm_nxt = asm_q;
      asm_nxt[idx*IN_WIDTH +: IN_WIDTH] = in_data;
      last    = (idx == CNT_W'(BEATS-1));
      in_ready = ((state_q == IDLE) ||
                  (state_q == LOAD) ||
                  (state_q == RUN)) && !cfg_abort;
      accept  = in_valid && in_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         set_q      <= '0;
         asm_q      <= '0;
         cfg        <= '0;
         cset       <= 1'b0;
         mac_en     <= 1'b0;
         cfg_loaded <= 1'b0;
      end else begin
         cset <= 1'b0;
         unique case (state_q)
            IDLE: mac_en <= 1'b0;
            LOAD: begin
               if (cfg_abort) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            end
            COMMIT: begin
               state_q <= SETTLE;
               set_q   <= '0;
            end
            SETTLE: begin
               if (set_q == SET_W'(SETTLE_CYCLES-1)) begin
                  state_q    <= RUN;
                  cfg_loaded <= 1'b1;
               end else begin
                  set_q <= set_q + 1'b1;
               end
            end
            RUN: mac_en <= run_en;
            default: state_q <= IDLE;
         endcase
         if (accept) begin
            asm_q      <= asm_nxt;
            mac_en     <= 1'b0;
            cfg_loaded <= 1'b0;
            if (last) begin
               cfg     <= CFG_WIDTH'(asm_nxt);
               cset    <= 1'b1;
               cnt_q   <= '0;
               state_q <= COMMIT;
            end else begin
               cnt_q   <= idx + 1'b1;
               state_q <= LOAD;
            end
         end
      end
   end

endmodule

// File: tb/tb_mac_cfg_loader.sv
// Scoreboard bench for mac_cfg_loader: expected cfg images are queued at
// issue time and checked by a monitor whenever cset pulses.
module tb_mac_cfg_loader;

   localparam int CW = 132;
   localparam int NB = 9;

   localparam logic [CW-1:0] IMG1 =
      132'h4444444433333333222222221111111D;
   localparam logic [CW-1:0] IMG2 =
      132'h89ABCDEF012345675A5A5A5AA5A5A5A52;
   localparam logic [CW-1:0] IMG3 =
      132'hDEADBEEFCAFEF00D0BADC0DE123456789;
   localparam logic [CW-1:0] IMG4 =
      132'h0000000100000002000000030000000E;
   localparam logic [CW-1:0] IMG5 =
      132'hFFFFFFFFEEEEEEEEDDDDDDDDCCCCCCCC7;
   localparam logic [CW-1:0] IMG6 =
      132'h13572468ACE0BDF19876543210FEDCBA5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [15:0]   in_data = '0;
   logic          cfg_abort = 1'b0;
   logic          run_en = 1'b0;
   logic [CW-1:0] cfg;
   logic          cset;
   logic          mac_en;
   logic          cfg_loaded;

   int checks = 0;
   int errors = 0;
   int accepts = 0;
   int csets = 0;
   logic [CW-1:0] exp_q[$];

   mac_cfg_loader dut (
      .clk(clk),
      .rst_n(rst_n),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .cfg_abort(cfg_abort),
      .run_en(run_en),
      .cfg(cfg),
      .cset(cset),
      .mac_en(mac_en),
      .cfg_loaded(cfg_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk_w(input string n, input logic [CW-1:0] a,
                        input logic [CW-1:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask

   task automatic chk_b(input string n, input logic a, input logic e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %b expected %b", n, a, e);
      end
   endtask

   task automatic chk_i(input string n, input int a, input int e);
      checks++;
      if (a != e) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", n, a, e);
      end
   endtask

   // Monitor: count accepted beats and check every cset against the queue
   always @(negedge clk) begin
      if (in_valid && in_ready) accepts++;
      if (cset === 1'b1) begin
         csets++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_cset: got cfg %h expected no cset", cfg);
         end else begin
            chk_w("cset_cfg", cfg, exp_q.pop_front());
         end
      end
   end

   function automatic logic [15:0] beat(input logic [CW-1:0] img,
                                        input int k);
      logic [NB*16-1:0] w;
      w = {12'h0, img};
      return w[k*16 +: 16];
   endfunction

   task automatic send_beat(input logic [15:0] d);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_data  = d;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (n >= 50) begin
         checks++;
         errors++;
         $display("FAIL beat_timeout: got in_ready 0 expected 1");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_range(input logic [CW-1:0] img, input int lo,
                             input int hi);
      for (int k = lo; k < hi; k++) send_beat(beat(img, k));
   endtask

   task automatic send_image(input logic [CW-1:0] img);
      exp_q.push_back(img);
      send_range(img, 0, NB);
   endtask

   // Called #1 after the edge that took the last beat
   task automatic check_settle();
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk_b($sformatf("cset_k%0d", k), cset, k == 0);
         chk_b($sformatf("mac_en_k%0d", k), mac_en, (k == 4) && run_en);
         chk_b($sformatf("loaded_k%0d", k), cfg_loaded, k >= 3);
      end
   endtask

   initial begin
      int a0;
      int c0;
      int i;
      int cyc;
      repeat (2) @(negedge clk);
      chk_w("rst_cfg", cfg, '0);
      chk_b("rst_cset", cset, 1'b0);
      chk_b("rst_mac_en", mac_en, 1'b0);
      chk_b("rst_loaded", cfg_loaded, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      run_en = 1'b1;
      @(negedge clk);
      chk_b("idle_ready", in_ready, 1'b1);

      // 1: basic load
      @(posedge clk);
      #1;
      send_image(IMG1);
      check_settle();
      chk_w("t1_cfg", cfg, IMG1);
      run_en = 1'b0;
      repeat (2) @(negedge clk);
      chk_b("t1_run_off", mac_en, 1'b0);
      run_en = 1'b1;
      repeat (2) @(negedge clk);
      chk_b("t1_run_on", mac_en, 1'b1);

      // 2: in_valid toggling every cycle
      @(posedge clk);
      #1;
      a0 = accepts;
      c0 = csets;
      exp_q.push_back(IMG2);
      i = 0;
      cyc = 0;
      while (i < NB && cyc < 100) begin
         in_valid = (cyc % 2) == 0;
         in_data  = beat(IMG2, i);
         @(negedge clk);
         if (in_valid && in_ready) i++;
         @(posedge clk);
         #1;
         cyc++;
      end
      in_valid = 1'b0;
      chk_i("t2_done", i, NB);
      check_settle();
      chk_i("t2_accepts", accepts - a0, NB);
      chk_i("t2_csets", csets - c0, 1);

      // 3: abort after 4 beats, then a full fresh image
      c0 = csets;
      send_range(IMG3, 0, 4);
      cfg_abort = 1'b1;
      @(negedge clk);
      chk_b("t3_abort_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      cfg_abort = 1'b0;
      repeat (3) @(negedge clk);
      chk_w("t3_cfg_kept", cfg, IMG2);
      chk_b("t3_loaded", cfg_loaded, 1'b0);
      chk_i("t3_no_cset", csets - c0, 0);
      @(posedge clk);
      #1;
      send_image(IMG3);
      check_settle();
      chk_i("t3_csets", csets - c0, 1);

      // 4: new beat in RUN drops mac_en on the accept edge
      chk_b("t4_mac_en_on", mac_en, 1'b1);
      @(posedge clk);
      #1;
      exp_q.push_back(IMG4);
      send_beat(beat(IMG4, 0));
      chk_b("t4_mac_en_drop", mac_en, 1'b0);
      chk_w("t4_cfg_hold", cfg, IMG3);
      send_range(IMG4, 1, NB);
      check_settle();

      // 5: asynchronous reset mid-load
      c0 = csets;
      send_range(IMG5, 0, 6);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk_w("t5_cfg", cfg, '0);
      chk_b("t5_cset", cset, 1'b0);
      chk_b("t5_mac_en", mac_en, 1'b0);
      chk_b("t5_loaded", cfg_loaded, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send_range(IMG5, 6, NB);
      repeat (4) @(negedge clk);
      chk_i("t5_no_cset", csets - c0, 0);
      chk_w("t5_cfg_zero", cfg, '0);
      @(posedge clk);
      #1;
      cfg_abort = 1'b1;
      @(posedge clk);
      #1;
      cfg_abort = 1'b0;

      // 6: abort with in_valid in LOAD
      send_range(IMG6, 0, 3);
      a0 = accepts;
      cfg_abort = 1'b1;
      in_valid  = 1'b1;
      in_data   = beat(IMG6, 3);
      @(negedge clk);
      chk_b("t6_ready", in_ready, 1'b0);
      @(posedge clk);
      #1;
      cfg_abort = 1'b0;
      in_valid  = 1'b0;
      chk_i("t6_no_accept", accepts - a0, 0);
      send_image(IMG6);
      check_settle();
      chk_w("t6_cfg", cfg, IMG6);

      repeat (5) @(negedge clk);
      chk_i("queue_empty", exp_q.size(), 0);
      chk_i("total_csets", csets, 5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
